// File: rtl/keccak_pkg.sv
// Shared definitions for the sequential Keccak theta engine: state geometry,
// FSM encoding and the lane-slice index helper.
package keccak_pkg;

  localparam int NUM_LANES = 25;
  localparam int ROW_LEN   = 5;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    APPLY,
    DONE
  } state_e;

  function automatic int lane_idx(input int x, input int y);
    return ROW_LEN * y + x;
  endfunction

endpackage

// File: rtl/keccak_lane_rotl.sv
// Constant left rotation of one W-bit lane; the amount is reduced modulo W so
// a full-width or single-bit lane degenerates to a wire.
module keccak_lane_rotl #(
  parameter int W   = 64,
  parameter int ROT = 1
) (
  input  logic [W-1:0] in_lane,
  output logic [W-1:0] out_lane
);

  localparam int R = ROT % W;

  generate
    if (R == 0) begin : g_pass
      assign out_lane = in_lane;
    end else begin : g_rot
      assign out_lane = {in_lane[W-1-R:0], in_lane[W-1:W-R]};
    end
  endgenerate

endmodule

// File: rtl/keccak_theta_seq.sv
// Row-serial Keccak theta: five cycles accumulate column parities C, five more
// cycles write out(x,y) = A[x,y] ^ D[x] one row at a time into the output buffer.
module keccak_theta_seq
  import keccak_pkg::*;
#(
  parameter int W   = 64,
  parameter int ROT = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NUM_LANES*W-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM_LANES*W-1:0] out_data
);

  localparam logic [2:0] LAST_ROW = 3'd4;

  state_e                   state_q, state_d;
  logic [2:0]               row_q, row_d;
  logic                     out_valid_q, out_valid_d;
  logic [NUM_LANES*W-1:0]   st_q, st_d;
  logic [NUM_LANES*W-1:0]   ob_q, ob_d;
  logic [ROW_LEN*W-1:0]     c_q, c_d;
  logic [W-1:0]             c_rot [ROW_LEN];
  logic [W-1:0]             d_lane [ROW_LEN];

  // D is purely combinational from the registered parities.
  generate
    for (genvar x = 0; x < ROW_LEN; x++) begin : g_d
      keccak_lane_rotl #(
        .W   (W),
        .ROT (ROT)
      ) u_rotl (
        .in_lane  (c_q[W*((x+1)%ROW_LEN) +: W]),
        .out_lane (c_rot[x])
      );
      assign d_lane[x] = c_q[W*((x+4)%ROW_LEN) +: W] ^ c_rot[x];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)          state_d = ACC;
      ACC:     if (row_q == LAST_ROW) state_d = APPLY;
      APPLY:   if (row_q == LAST_ROW) state_d = DONE;
      DONE:    if (out_ready)         state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = out_valid_q;
    out_data  = ob_q;
  end

  always_comb begin
    st_d        = st_q;
    c_d         = c_q;
    ob_d        = ob_q;
    row_d       = row_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          st_d  = in_data;
          c_d   = '0;
          row_d = 3'd0;
        end
      end
      ACC: begin
        for (int x = 0; x < ROW_LEN; x++) begin
          c_d[W*x +: W] = c_q[W*x +: W] ^ st_q[W*lane_idx(x, int'(row_q)) +: W];
        end
        row_d = (row_q == LAST_ROW) ? 3'd0 : row_q + 3'd1;
      end
      APPLY: begin
        for (int x = 0; x < ROW_LEN; x++) begin
          ob_d[W*lane_idx(x, int'(row_q)) +: W] =
            st_q[W*lane_idx(x, int'(row_q)) +: W] ^ d_lane[x];
        end
        row_d = (row_q == LAST_ROW) ? 3'd0 : row_q + 3'd1;
        if (row_q == LAST_ROW) out_valid_d = 1'b1;
      end
      DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Control and visible results are cleared on reset; the input copy is not.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q       <= 3'd0;
      out_valid_q <= 1'b0;
      c_q         <= '0;
      ob_q        <= '0;
    end else begin
      row_q       <= row_d;
      out_valid_q <= out_valid_d;
      c_q         <= c_d;
      ob_q        <= ob_d;
    end
  end

  always_ff @(posedge clk) begin
    st_q <= st_d;
  end

endmodule

// File: doc/keccak_theta_seq.md
# keccak_theta_seq

Parametrised, sequential Keccak θ (theta) engine for a 5×5 state of W-bit lanes. It replaces the single-cycle, 1-bit-lane column-parity block with a row-serial datapath that accumulates column parities over 5 cycles and applies them over 5 cycles. It adds the lane rotation on the C[x+1] term and a valid/ready handshake on both sides. It sits between the state register and the ρ/π stage of the permutation datapath.

## Interface
- W, default 64: lane width in bits; legal range 1..64.
- ROT, default 1: left-rotation applied to C[x+1]; taken modulo W, so it is a no-op when W=1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous and active-high.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a state.
- in_data  input  25*W  state; lane (x,y) at bits [W*(5*y+x) +: W].
- out_valid  output  1  out_data holds a finished result.
- out_ready  input  1  consumer accepts the result.
- out_data  output  25*W  θ result, same lane layout as in_data.

## Operation
- Function:
  - C[x] = XOR over y of A[x,y].
  - D[x] = C[(x+4)%5] ^ rotl(C[(x+1)%5], ROT%W).
  - out(x,y) = A[x,y] ^ D[x].
- States:
  - IDLE: in_ready=1. On in_valid, capture in_data into the state buffer, clear C[0..4], row counter y←0, go to ACC.
  - ACC: at each edge, C[x] ^= A[x,y] for all x, y++. Leave after y=4 with y←0, go to APPLY.
  - APPLY: D is combinational from C. At each edge, write out row y (out(x,y) for x=0..4) into the output buffer, y++. After y=4, set out_valid, go to DONE.
  - DONE: out_valid=1, out_data stable. On out_ready, clear out_valid and go to IDLE.
- in_ready is 1 only in IDLE. There is no same-cycle bypass from DONE to accepting a new state.
- in_data is ignored outside IDLE. in_valid may drop in the cycle after the handshake.
- Arithmetic: all operations are bitwise XOR and rotation. There is no carry and no width growth. C and D are W bits each.
- Row counter is 3 bits. It counts 0..4 and never wraps past 4.
- Reset (including mid-ACC or mid-APPLY):
  - state←IDLE; in_ready=1 in the next cycle.
  - out_valid=0; out_data=0; C=0; y=0.
  - The in-flight state is discarded.
- rst has priority over in_valid and out_ready in the same cycle.

## Timing
- Handshake at edge E0.
- ACC updates at edges E1..E5.
- APPLY writes at edges E6..E10.
- out_valid high from edge E10, i.e. 10 cycles from accept to result.
- Minimum initiation interval is 12 cycles: accept, 10 processing cycles, 1 DONE cycle with out_ready=1. The next in_ready rises after the out handshake edge.
- out_data and out_valid are registered outputs. in_ready is decoded from the state register.
- Back-pressure: DONE is held indefinitely with out_data stable and in_ready=0.

## Structure
- Shared package keccak_pkg holds:
  - NUM_LANES=25 and ROW_LEN=5.
  - The state enum {IDLE, ACC, APPLY, DONE}.
  - Lane-slice index helper lane_idx(x,y)=5*y+x.
- Sub-module keccak_lane_rotl: parameters W and ROT, combinational constant left rotation. Instantiated ×5 for the rotl(C[x+1]) terms.
- Top module holds:
  - FSM and row counter.
  - State buffer (25*W).
  - C registers (5*W).
  - Output buffer (25*W).
  - Row write-select muxing.

## Test plan
- All-zero state, W=1, ROT=1 -> out_data=0. out_valid rises exactly 10 cycles after the accept edge.
- W=8, only lane (0,0)=0x01 -> out lane (0,0)=0x01; lanes (1,y)=0x01 for all y; lanes (4,y)=0x02 for all y; all other lanes 0x00.
- W=8, all lanes 0xFF -> C[x]=0xFF and D[x]=0x00, so out_data is all ones.
- Back-pressure, W=64: hold out_ready=0 for 20 cycles after out_valid.
  - out_data stays constant and in_ready=0 throughout.
  - Raising out_ready drops out_valid at the next edge; in_ready=1 the cycle after.
- Assert rst at cycle 7 after accept (mid-APPLY) -> next cycle out_valid=0, out_data=0, in_ready=1. A new state accepted afterwards yields the correct θ result with no residue from the aborted state.
- Back-to-back random states, W=64, ROT=1, out_ready tied 1: 100 random vectors compared against a reference model -> all match, with an initiation interval of 12 cycles.
